// File: rtl/reg_wb_arbiter_pkg.sv
// rtl/reg_wb_arbiter_pkg.sv - shared widths, FIFO depth default and write-back source encoding
package reg_wb_arbiter_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_NUMBER     = 32;
    localparam int WB_FIFO_DEPTH  = 4;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_LSU  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// rtl/reg_wb_arbiter_if.sv - execute/LSU/decode side bundle of the write-back arbiter
interface reg_wb_arbiter_if
    import reg_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int REG_NUMBER = reg_wb_arbiter_pkg::REG_NUMBER
);
    logic                  i_AluWrEn;
    logic [ADDR_WIDTH-1:0] i_AluWrAddr;
    logic [DATA_WIDTH-1:0] i_AluWrData;
    logic                  i_LsuValid;
    logic                  o_LsuReady;
    logic [ADDR_WIDTH-1:0] i_LsuAddr;
    logic [DATA_WIDTH-1:0] i_LsuData;
    logic                  i_IssueEn;
    logic [ADDR_WIDTH-1:0] i_IssueRd;
    logic [ADDR_WIDTH-1:0] i_Rs1Addr;
    logic [ADDR_WIDTH-1:0] i_Rs2Addr;
    logic [ADDR_WIDTH-1:0] i_DecRd;
    logic                  o_Stall;
    logic                  o_RegWrEn;
    logic [ADDR_WIDTH-1:0] o_RegWrAddr;
    logic [DATA_WIDTH-1:0] o_RegWrData;
    logic [REG_NUMBER-1:0] o_BusyMask;

    modport slave (
        input  i_AluWrEn, i_AluWrAddr, i_AluWrData,
        input  i_LsuValid, i_LsuAddr, i_LsuData,
        input  i_IssueEn, i_IssueRd, i_Rs1Addr, i_Rs2Addr, i_DecRd,
        output o_LsuReady, o_Stall, o_RegWrEn, o_RegWrAddr, o_RegWrData, o_BusyMask
    );

    modport master (
        output i_AluWrEn, i_AluWrAddr, i_AluWrData,
        output i_LsuValid, i_LsuAddr, i_LsuData,
        output i_IssueEn, i_IssueRd, i_Rs1Addr, i_Rs2Addr, i_DecRd,
        input  o_LsuReady, o_Stall, o_RegWrEn, o_RegWrAddr, o_RegWrData, o_BusyMask
    );

endinterface

// File: rtl/reg_wb_arbiter_fifo.sv
// rtl/reg_wb_arbiter_fifo.sv - wb_result_fifo: synchronous circular buffer for LSU results
module wb_result_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - merges ALU and buffered LSU results onto the single register-file write port
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int REG_NUMBER = reg_wb_arbiter_pkg::REG_NUMBER,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    reg_wb_arbiter_if.slave   bus
);
    localparam int FW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [$clog2(FIFO_DEPTH):0] CNT_FULL = ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH);

    logic [FW-1:0]                 head;
    logic [ADDR_WIDTH-1:0]         head_addr;
    logic [DATA_WIDTH-1:0]         head_data;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          lsu_ready;
    logic                          push;
    logic                          pop;
    wb_src_e                       sel;
    logic                          nxt_en;
    logic [ADDR_WIDTH-1:0]         nxt_addr;
    logic [DATA_WIDTH-1:0]         nxt_data;
    logic                          wr_en_q;
    logic [ADDR_WIDTH-1:0]         wr_addr_q;
    logic [DATA_WIDTH-1:0]         wr_data_q;
    logic [REG_NUMBER-1:0]         busy_q;
    logic [REG_NUMBER-1:0]         busy_nxt;
    logic [REG_NUMBER-1:0]         busy_eff;

    assign head_addr = head[FW-1:DATA_WIDTH];
    assign head_data = head[DATA_WIDTH-1:0];
    assign lsu_ready = (fifo_count != CNT_FULL);
    assign push      = bus.i_LsuValid && lsu_ready;
    assign pop       = (sel == WB_SRC_LSU);

    wb_result_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({bus.i_LsuAddr, bus.i_LsuData}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ALU results cannot be held back, so they always win the port; x0 targets are consumed silently.
    always_comb begin
        sel      = WB_SRC_NONE;
        nxt_en   = 1'b0;
        nxt_addr = '0;
        nxt_data = '0;
        if (bus.i_AluWrEn) begin
            sel      = WB_SRC_ALU;
            nxt_en   = (bus.i_AluWrAddr != '0);
            nxt_addr = bus.i_AluWrAddr;
            nxt_data = bus.i_AluWrData;
        end else if (!fifo_empty) begin
            sel      = WB_SRC_LSU;
            nxt_en   = (head_addr != '0);
            nxt_addr = head_addr;
            nxt_data = head_data;
        end
    end

    // Clear before set so a same-cycle re-issue keeps the register pending.
    always_comb begin
        busy_nxt = busy_q;
        if (sel == WB_SRC_LSU) busy_nxt[head_addr] = 1'b0;
        if (bus.i_IssueEn && (bus.i_IssueRd != '0)) busy_nxt[bus.i_IssueRd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wr_en_q   <= nxt_en;
            wr_addr_q <= nxt_addr;
            wr_data_q <= nxt_data;
            busy_q    <= busy_nxt;
        end
    end

    assign busy_eff = {busy_q[REG_NUMBER-1:1], 1'b0};

    assign bus.o_LsuReady  = lsu_ready;
    assign bus.o_Stall     = busy_eff[bus.i_Rs1Addr] | busy_eff[bus.i_Rs2Addr] |
                             busy_eff[bus.i_DecRd] | fifo_full;
    assign bus.o_RegWrEn   = wr_en_q;
    assign bus.o_RegWrAddr = wr_addr_q;
    assign bus.o_RegWrData = wr_data_q;
    assign bus.o_BusyMask  = busy_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - directed self-checking bench for reg_wb_arbiter
module tb_reg_wb_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .REG_NUMBER(32)) bus ();

    reg_wb_arbiter #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32),
        .REG_NUMBER (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.i_AluWrEn   = 1'b0;
        bus.i_AluWrAddr = '0;
        bus.i_AluWrData = '0;
        bus.i_LsuValid  = 1'b0;
        bus.i_LsuAddr   = '0;
        bus.i_LsuData   = '0;
        bus.i_IssueEn   = 1'b0;
        bus.i_IssueRd   = '0;
        bus.i_Rs1Addr   = '0;
        bus.i_Rs2Addr   = '0;
        bus.i_DecRd     = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_en",    bus.o_RegWrEn,   0);
        chk("rst_addr",  bus.o_RegWrAddr, 0);
        chk("rst_data",  bus.o_RegWrData, 0);
        chk("rst_ready", bus.o_LsuReady,  1);
        chk("rst_stall", bus.o_Stall,     0);
        chk("rst_busy",  bus.o_BusyMask,  0);

        // single ALU write, visible one cycle later only
        bus.i_AluWrEn = 1'b1; bus.i_AluWrAddr = 5; bus.i_AluWrData = 32'h1234;
        tick();
        bus.i_AluWrEn = 1'b0;
        chk("alu_en",   bus.o_RegWrEn,   1);
        chk("alu_addr", bus.o_RegWrAddr, 5);
        chk("alu_data", bus.o_RegWrData, 32'h1234);
        tick();
        chk("alu_gone", bus.o_RegWrEn, 0);

        // ALU and LSU in the same cycle
        bus.i_AluWrEn = 1'b1; bus.i_AluWrAddr = 3; bus.i_AluWrData = 32'h33;
        bus.i_LsuValid = 1'b1; bus.i_LsuAddr = 7; bus.i_LsuData = 32'hBEEF;
        tick();
        bus.i_AluWrEn = 1'b0; bus.i_LsuValid = 1'b0;
        chk("both_alu_addr", bus.o_RegWrAddr, 3);
        chk("both_alu_data", bus.o_RegWrData, 32'h33);
        tick();
        chk("both_lsu_en",   bus.o_RegWrEn,   1);
        chk("both_lsu_addr", bus.o_RegWrAddr, 7);
        chk("both_lsu_data", bus.o_RegWrData, 32'hBEEF);
        tick();
        chk("both_idle", bus.o_RegWrEn, 0);

        // ALU hogs the port while the FIFO fills
        bus.i_AluWrEn = 1'b1; bus.i_AluWrAddr = 1;
        for (int k = 1; k <= 4; k++) begin
            bus.i_AluWrData = 32'hA0 + k;
            bus.i_LsuValid  = 1'b1; bus.i_LsuAddr = 5'(10 + k); bus.i_LsuData = k;
            #1;
            chk("fill_ready", bus.o_LsuReady, 1);
            tick();
            chk("fill_alu_data", bus.o_RegWrData, 32'hA0 + k);
        end
        bus.i_AluWrData = 32'hA5; bus.i_LsuAddr = 15; bus.i_LsuData = 5;
        #1;
        chk("full_ready", bus.o_LsuReady, 0);
        chk("full_stall", bus.o_Stall,    1);
        tick();
        chk("full_alu_data", bus.o_RegWrData, 32'hA5);
        bus.i_AluWrEn = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("drain_en",   bus.o_RegWrEn,   1);
            chk("drain_addr", bus.o_RegWrAddr, 10 + i);
            chk("drain_data", bus.o_RegWrData, i);
            if (i == 2) bus.i_LsuValid = 1'b0;
        end
        tick();
        chk("drain_done", bus.o_RegWrEn, 0);

        // RAW/WAW hazard on a pending load destination
        bus.i_IssueEn = 1'b1; bus.i_IssueRd = 9;
        tick();
        bus.i_IssueEn = 1'b0; bus.i_Rs1Addr = 9;
        #1;
        chk("raw_stall", bus.o_Stall,    1);
        chk("raw_busy",  bus.o_BusyMask, 32'h200);
        bus.i_Rs1Addr = 0; bus.i_DecRd = 9;
        #1;
        chk("waw_stall", bus.o_Stall, 1);
        bus.i_DecRd = 0; bus.i_Rs1Addr = 9;
        bus.i_LsuValid = 1'b1; bus.i_LsuAddr = 9; bus.i_LsuData = 32'h99;
        tick();
        bus.i_LsuValid = 1'b0;
        chk("raw_buffered_stall", bus.o_Stall,    1);
        chk("raw_buffered_busy",  bus.o_BusyMask, 32'h200);
        tick();
        chk("raw_wr_en",    bus.o_RegWrEn,   1);
        chk("raw_wr_addr",  bus.o_RegWrAddr, 9);
        chk("raw_wr_data",  bus.o_RegWrData, 32'h99);
        chk("raw_cleared",  bus.o_BusyMask,  0);
        chk("raw_released", bus.o_Stall,     0);
        bus.i_Rs1Addr = 0;

        // set wins over clear on the same register
        bus.i_IssueEn = 1'b1; bus.i_IssueRd = 4;
        tick();
        bus.i_IssueEn = 1'b0;
        bus.i_LsuValid = 1'b1; bus.i_LsuAddr = 4; bus.i_LsuData = 32'h44;
        tick();
        bus.i_LsuValid = 1'b0; bus.i_IssueEn = 1'b1;
        tick();
        bus.i_IssueEn = 1'b0;
        chk("setwin_addr", bus.o_RegWrAddr, 4);
        chk("setwin_busy", bus.o_BusyMask,  32'h10);
        bus.i_LsuValid = 1'b1; bus.i_LsuData = 32'h45;
        tick();
        bus.i_LsuValid = 1'b0;
        tick();
        chk("setwin_data",  bus.o_RegWrData, 32'h45);
        chk("setwin_clear", bus.o_BusyMask,  0);

        // x0 destinations
        bus.i_AluWrEn = 1'b1; bus.i_AluWrAddr = 0; bus.i_AluWrData = 5;
        tick();
        bus.i_AluWrEn = 1'b0;
        chk("x0_alu_en", bus.o_RegWrEn, 0);
        bus.i_LsuValid = 1'b1; bus.i_LsuAddr = 0; bus.i_LsuData = 6;
        tick();
        bus.i_LsuValid = 1'b0;
        tick();
        chk("x0_lsu_en", bus.o_RegWrEn, 0);
        bus.i_IssueEn = 1'b1; bus.i_IssueRd = 0;
        tick();
        bus.i_IssueEn = 1'b0;
        chk("x0_busy",  bus.o_BusyMask, 0);
        chk("x0_stall", bus.o_Stall,    0);
        tick();
        chk("x0_drained", bus.o_RegWrEn, 0);

        // reset with FIFO holding three entries and a pending register
        bus.i_AluWrEn = 1'b1; bus.i_AluWrAddr = 2; bus.i_AluWrData = 32'h22;
        bus.i_IssueEn = 1'b1; bus.i_IssueRd = 6;
        for (int k = 1; k <= 3; k++) begin
            bus.i_LsuValid = 1'b1; bus.i_LsuAddr = 5'(20 + k); bus.i_LsuData = 32'h100 + k;
            tick();
        end
        bus.i_IssueEn = 1'b0; bus.i_LsuValid = 1'b0;
        chk("pre_rst_ready", bus.o_LsuReady, 1);
        chk("pre_rst_busy",  bus.o_BusyMask, 32'h40);
        reset = 1'b1;
        tick();
        reset = 1'b0; bus.i_AluWrEn = 1'b0;
        #1;
        chk("mid_rst_en",    bus.o_RegWrEn,  0);
        chk("mid_rst_data",  bus.o_RegWrData, 0);
        chk("mid_rst_busy",  bus.o_BusyMask, 0);
        chk("mid_rst_ready", bus.o_LsuReady, 1);
        chk("mid_rst_stall", bus.o_Stall,    0);
        tick();
        chk("mid_rst_empty1", bus.o_RegWrEn, 0);
        tick();
        chk("mid_rst_empty2", bus.o_RegWrEn, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
